// File: rtl/decision_pkg.sv
// Shared class-code and FSM definitions for the majority-vote stage and the
// downstream light stage, so the class code range is defined in one place.
package decision_pkg;

  localparam int unsigned NUM_CLASSES_DEF = 5;
  localparam int unsigned ANS_W           = 3;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SCAN    = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/class_vote_counter.sv
// Single per-class vote counter with synchronous clear and count enable.
module class_vote_counter #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/final_decision.sv
// Majority vote over a window of class codes; sequential scan picks the winner.
// Optional confidence gate: define FINAL_DECISION_MIN_CONF_EN.
module final_decision
  import decision_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int unsigned WINDOW      = 16,
  parameter int unsigned CNT_W       = $clog2(WINDOW + 1),
  parameter int unsigned MIN_VOTES   = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ANS_W-1:0] sampleAnswer,
  input  logic             sampleValid,
  output logic [ANS_W-1:0] finalAnswer,
  output logic             finalDone,
  output logic             busy,
  output logic             lowConf
);

  state_t                               state;
  logic [CNT_W-1:0]                     win_cnt;
  logic [CNT_W-1:0]                     best_cnt;
  logic [ANS_W-1:0]                     scan_idx;
  logic [ANS_W-1:0]                     best_idx;
  logic [NUM_CLASSES-1:0][CNT_W-1:0]    counts;

  logic                                 accept;
  logic                                 clear_cnt;
  logic                                 take;
  logic                                 last_scan;
  logic [ANS_W-1:0]                     nbest_idx;
  logic [CNT_W-1:0]                     nbest_cnt;

  if (NUM_CLASSES > (1 << ANS_W)) begin : g_bad_classes
    $error("NUM_CLASSES does not fit in the answer width");
  end
  if (MIN_VOTES > WINDOW) begin : g_bad_min_votes
    $error("MIN_VOTES exceeds WINDOW");
  end

  always_comb begin
    accept    = (state == COLLECT) && sampleValid && (32'(sampleAnswer) < NUM_CLASSES);
    clear_cnt = (state == DONE);
    take      = counts[scan_idx] > best_cnt;
    nbest_idx = take ? scan_idx : best_idx;
    nbest_cnt = take ? counts[scan_idx] : best_cnt;
    last_scan = (scan_idx == ANS_W'(NUM_CLASSES - 1));
  end

  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_cnt
    class_vote_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (clear_cnt),
      .en    (accept && (sampleAnswer == ANS_W'(g))),
      .count (counts[g])
    );
  end

  // The decision is registered on the last scan edge so that finalDone and
  // the new finalAnswer are visible for exactly the DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= COLLECT;
      win_cnt     <= '0;
      scan_idx    <= '0;
      best_idx    <= '0;
      best_cnt    <= '0;
      finalAnswer <= '0;
      finalDone   <= 1'b0;
      busy        <= 1'b0;
      lowConf     <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            if (win_cnt == CNT_W'(WINDOW - 1)) begin
              state   <= SCAN;
              busy    <= 1'b1;
              win_cnt <= '0;
            end else begin
              win_cnt <= win_cnt + 1'b1;
            end
          end
        end
        SCAN: begin
          best_idx <= nbest_idx;
          best_cnt <= nbest_cnt;
          scan_idx <= scan_idx + 1'b1;
          if (last_scan) begin
            state <= DONE;
`ifdef FINAL_DECISION_MIN_CONF_EN
            if (nbest_cnt < CNT_W'(MIN_VOTES)) begin
              lowConf <= 1'b1;
            end else begin
              finalDone   <= 1'b1;
              finalAnswer <= nbest_idx;
            end
`else
            finalDone   <= 1'b1;
            finalAnswer <= nbest_idx;
`endif
          end
        end
        DONE: begin
          state     <= COLLECT;
          busy      <= 1'b0;
          finalDone <= 1'b0;
          lowConf   <= 1'b0;
          scan_idx  <= '0;
          best_idx  <= '0;
          best_cnt  <= '0;
          win_cnt   <= '0;
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: doc/final_decision.md
# final_decision

Majority-vote stage that sits directly upstream of the output-decision/light-driver stage. It accepts a stream of per-sample class codes from the classifier, tallies votes per class over a fixed window, and scans the tallies for the winner. It then presents the winning class on `finalAnswer` with a one-cycle `finalDone` strobe, which is the form the downstream light stage consumes.

## Interface
Parameters:
- `NUM_CLASSES`, 5: number of valid class codes (0..NUM_CLASSES-1).
- `WINDOW`, 16: accepted samples per decision.
- `CNT_W`, $clog2(WINDOW+1): per-class counter width.
- `MIN_VOTES`, 9: confidence threshold; used only when `FINAL_DECISION_MIN_CONF_EN` is defined.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: rising-edge clock.
- `reset`, in, 1: synchronous, active-high; clears all state.
- `sampleAnswer`, in, 3: class code of the current sample.
- `sampleValid`, in, 1: `sampleAnswer` is valid this cycle.
- `finalAnswer`, out, 3: winning class; holds its value until the next decision.
- `finalDone`, out, 1: one-cycle strobe; `finalAnswer` is new this cycle.
- `busy`, out, 1: high while in SCAN or DONE; samples are dropped.
- `lowConf`, out, 1: one-cycle strobe on a rejected decision; tied 0 when the feature is off.

## Operation
- States: COLLECT (reset state), SCAN, DONE.
- COLLECT:
  - Sample accepted when `sampleValid`=1 and `sampleAnswer` < NUM_CLASSES.
  - On acceptance, the matching class counter and the window counter each increment by 1.
  - Codes >= NUM_CLASSES are discarded: no counter changes.
  - When the window counter reaches WINDOW on an accepted sample, next state is SCAN.
- SCAN:
  - Lasts exactly NUM_CLASSES cycles; index i = 0..NUM_CLASSES-1, one class per cycle.
  - Class i replaces the running best only if count[i] > best count (strict).
  - Ties therefore resolve to the lowest class index.
  - After index NUM_CLASSES-1, next state is DONE.
- DONE (1 cycle):
  - `finalAnswer` <= best index; `finalDone` = 1.
  - All counters and best registers clear.
  - Next state is COLLECT.
- Samples presented in SCAN or DONE are dropped, not queued.
- Counters cannot overflow: the sum of class counts is at most WINDOW, which fits in CNT_W bits.
- Reset has priority over everything, including a reset in the middle of a window or in the middle of a scan. It returns the block to COLLECT with all counters cleared. The partial window is lost and no strobe is issued.

## Timing
- Reset values: `finalAnswer`=0, `finalDone`=0, `busy`=0, `lowConf`=0, state=COLLECT.
- Latency:
  - Last accepted sample at edge t.
  - SCAN occupies cycles t+1..t+NUM_CLASSES.
  - `finalDone` is high for exactly the single cycle t+NUM_CLASSES+1 (t+6 at default).
- `busy` is high from cycle t+1 through the DONE cycle. Its first sample-accepting cycle is the one after DONE.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `sampleValid` with a discarded code during COLLECT causes no state change.
- Decisions are issued no more often than once every WINDOW+NUM_CLASSES+1 cycles.

## Configuration
- `FINAL_DECISION_MIN_CONF_EN` defined:
  - In DONE, if best count < MIN_VOTES: `finalDone` stays 0, `lowConf` pulses 1, and `finalAnswer` keeps its previous value.
  - Otherwise behaviour is normal.
  - Counters clear and the block returns to COLLECT either way.
- Not defined:
  - `lowConf` is constant 0.
  - Every completed window produces a `finalDone` strobe regardless of the vote distribution.

## Structure
- Shared package `decision_pkg` holds:
  - NUM_CLASSES default and answer width (3).
  - State encodings (COLLECT=0, SCAN=1, DONE=2).
  - These are shared with the downstream light stage so the class code range is defined once.
- One sub-module: `class_vote_counter`.
  - A single CNT_W-bit counter with clear and enable.
  - Instantiated NUM_CLASSES times.
- The scan/compare datapath and the FSM live in the top level.

## Test plan
- Reset, then 16 accepted samples of class 2 on consecutive cycles -> `finalAnswer`=2, `finalDone` high for exactly one cycle, 6 cycles after the last sample; `busy` high for 6 cycles.
- 8× class 1 and 8× class 3, interleaved -> `finalAnswer`=1 (lowest-index tie-break).
- 16× class 4 with codes 5, 6, 7 interleaved between them -> invalid codes ignored; the window completes only after the 16th class-4 sample; `finalAnswer`=4.
- A full window of class 0, then 3 samples of class 1 driven during SCAN/DONE, then 16× class 3 -> first decision 0; second decision 3; the class-1 samples have no effect.
- 10 samples of class 2, `reset` pulse, then 16× class 1 -> no strobe around the reset; the next decision is 1 after exactly 16 post-reset samples.
- With `FINAL_DECISION_MIN_CONF_EN`: 6× class 0, 5× class 1, 5× class 4 -> `lowConf` pulses, `finalDone` stays 0, `finalAnswer` unchanged. A following window of 9× class 3 plus 7× class 0 -> `finalDone`, `finalAnswer`=3.
